mult_hilo_ctrl: RTL and testbench
=================================

Name: mult_hilo_ctrl

Overview:
Sequencer between the multi-cycle datapath control and the booth multiplier.
- Accepts a multiply request and latches its operands.
- Issues a one-cycle start to the multiplier, waits for its valid, and splits the 2*DATA_WIDTH product into HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO, and stalls the datapath while a multiply is in flight.

Parameters:
DATA_WIDTH, 32, operand width; product is 2*DATA_WIDTH, HI and LO are DATA_WIDTH each
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with MUL_TIMEOUT_EN)

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  reset, synchronous, active-high
req  input  1  start multiply of op_a*op_b (signed)
op_a  input  DATA_WIDTH  multiplicand
op_b  input  DATA_WIDTH  multiplier
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when HI/LO updated from a product
mul_start  output  1  to multiplier start
mul_op1  output  DATA_WIDTH  to multiplier Operand1 (latched op_a)
mul_op2  output  DATA_WIDTH  to multiplier Operand2 (latched op_b)
mul_result  input  2*DATA_WIDTH  from multiplier result
mul_valid  input  1  from multiplier valid
mfhi  input  1  read HI
mflo  input  1  read LO
mthi  input  1  write wr_data to HI
mtlo  input  1  write wr_data to LO
wr_data  input  DATA_WIDTH  move-to data
rd_data  output  DATA_WIDTH  HI if mfhi, else LO if mflo, else 0 (combinational)
stall  output  1  (mfhi|mflo|mthi|mtlo) & busy
err  output  1  sticky timeout flag (MUL_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (synchronous, RST=1 at rising edge):
  - State goes to IDLE.
  - HI, LO, the operand latches and err clear to 0.
  - busy, done and mul_start read 0.
  - Reset mid-operation abandons the multiply; a late mul_valid after reset is ignored.
- States:
  - IDLE: req=1 latches op_a/op_b -> ISSUE.
  - ISSUE: mul_start=1 for exactly one cycle, with the latched operands on mul_op1/mul_op2 -> WAIT.
  - WAIT: on mul_valid=1, capture HI=mul_result[2W-1:W] and LO=mul_result[W-1:0] -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency: from req accepted to done = 3 cycles + multiplier latency. HI/LO are readable in the DONE cycle.
- mul_op1/mul_op2 hold the latched values from ISSUE through DONE.
- req while busy is ignored; the requester must wait for busy=0.
- mul_valid outside WAIT is ignored.
- Moves and reads:
  - mthi/mtlo write on the clock edge only when busy=0.
  - While busy, moves are suppressed and stall=1.
  - rd_data is always driven from current HI/LO; stall tells the datapath it is stale.
- Simultaneous events in IDLE:
  - req + mthi/mtlo: the move takes effect and the request is accepted; the product later overwrites both HI and LO.
  - mthi + mtlo together: both registers are written.
- No internal arithmetic: product width and sign are the multiplier's responsibility. The controller only slices the result.

Optional Feature:
MUL_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mul_valid: err sets (sticky until RST), state -> IDLE, HI/LO unchanged, done not pulsed.
- Undefined: no counter; WAIT lasts indefinitely and err is constant 0.

Decomposition:
- Package mult_hilo_pkg holds:
  - the state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - default DATA_WIDTH/TIMEOUT_CYCLES constants;
  - the HI/LO select encoding.
- Sub-module hilo_regs: the HI/LO register pair with write-enable, product-load and read mux. The FSM stays in mult_hilo_ctrl.

Test Plan:
1. DATA_WIDTH=5, reset, req with op_a=01011, op_b=01110, model multiplier valid after 6 cycles with result 154 -> mul_start pulses once, done one cycle after valid, HI=4 and LO=26, mfhi then reads 4.
2. op_a=-3 (11101), op_b=7, product 1003 (0b1111101011) -> HI=31, LO=11.
3. mflo and mthi asserted during WAIT -> stall=1, HI unchanged; after done, mthi with wr_data=9 -> HI=9, stall=0.
4. Second req while busy -> ignored, only one mul_start; RST asserted mid-WAIT followed by a late mul_valid -> state IDLE, HI/LO=0, done never pulses.
5. Same-cycle req + mtlo(wr_data=5) in IDLE -> LO=5 next cycle, then overwritten by the product at done.
6. With MUL_TIMEOUT_EN and TIMEOUT_CYCLES=8, mul_valid never asserted -> err=1 after 8 WAIT cycles, busy=0, HI/LO unchanged, err stays high until RST.

Source files
------------

// File: rtl/mult_hilo_pkg.sv
// Shared types and defaults for the multiply HI/LO sequencer.
// Holds the FSM state encoding, the HI/LO read-select encoding and default sizes.
package mult_hilo_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_HI   = 2'd1,
        SEL_LO   = 2'd2
    } rd_sel_e;

    // HI wins when both reads are requested.
    function automatic rd_sel_e rd_sel(input logic mfhi, input logic mflo);
        rd_sel_e s;
        s = SEL_NONE;
        if (mfhi)
            s = SEL_HI;
        else if (mflo)
            s = SEL_LO;
        return s;
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair: move-to writes, product load and read mux.
// Ports: clk_i/rst_i (sync, active-high), we_hi_i/we_lo_i + wr_data_i,
//        load_i + product_i (2W), sel_i read select, rd_data_o.
module hilo_regs
    import mult_hilo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_hi_i,
    input  logic                    we_lo_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    load_i,
    input  logic [2*DATA_WIDTH-1:0] product_i,
    input  rd_sel_e                 sel_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    // Product load and moves are never enabled together (moves only in IDLE).
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (load_i) begin
            hi_d = product_i[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_d = product_i[DATA_WIDTH-1:0];
        end else begin
            if (we_hi_i)
                hi_d = wr_data_i;
            if (we_lo_i)
                lo_d = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        unique case (sel_i)
            SEL_HI:  rd_data_o = hi_q;
            SEL_LO:  rd_data_o = lo_q;
            default: rd_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer between datapath control and the multiplier; owns HI/LO.
// Ports: CLK/RST, req+op_a/op_b, busy/done/stall/err, mul_* multiplier link,
//        mfhi/mflo/mthi/mtlo + wr_data/rd_data. Optional: MUL_TIMEOUT_EN.
module mult_hilo_ctrl
    import mult_hilo_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    busy,
    output logic                    done,
    output logic                    mul_start,
    output logic [DATA_WIDTH-1:0]   mul_op1,
    output logic [DATA_WIDTH-1:0]   mul_op2,
    input  logic [2*DATA_WIDTH-1:0] mul_result,
    input  logic                    mul_valid,
    input  logic                    mfhi,
    input  logic                    mflo,
    input  logic                    mthi,
    input  logic                    mtlo,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    stall,
    output logic                    err
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic                  load;

`ifdef MUL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        mul_start = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
`ifdef MUL_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    opa_d   = op_a;
                    opb_d   = op_b;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_start = 1'b1;
                state_d   = ST_WAIT;
`ifdef MUL_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_WAIT: begin
                if (mul_valid) begin
                    load    = 1'b1;
                    state_d = ST_DONE;
                end
`ifdef MUL_TIMEOUT_EN
                // Last allowed WAIT cycle without valid: abandon the multiply.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

`ifdef MUL_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy    = (state_q != ST_IDLE);
    assign stall   = (mfhi | mflo | mthi | mtlo) & busy;
    assign mul_op1 = opa_q;
    assign mul_op2 = opb_q;

    hilo_regs #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_hilo (
        .clk_i     (CLK),
        .rst_i     (RST),
        .we_hi_i   (mthi & ~busy),
        .we_lo_i   (mtlo & ~busy),
        .wr_data_i (wr_data),
        .load_i    (load),
        .product_i (mul_result),
        .sel_i     (rd_sel(mfhi, mflo)),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl at DATA_WIDTH=5.
// Timeout section is built only when MUL_TIMEOUT_EN is defined.
module tb_mult_hilo_ctrl;

    localparam int W = 5;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, mul_start;
    logic [W-1:0] mul_op1, mul_op2;
    logic [2*W-1:0] mul_result;
    logic         mul_valid;
    logic         mfhi, mflo, mthi, mtlo;
    logic [W-1:0] wr_data, rd_data;
    logic         stall, err;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int dones  = 0;
    int s0, d0;

    always #5 CLK = ~CLK;

    mult_hilo_ctrl #(
        .DATA_WIDTH(W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .mul_start  (mul_start),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_result (mul_result),
        .mul_valid  (mul_valid),
        .mfhi       (mfhi),
        .mflo       (mflo),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .stall      (stall),
        .err        (err)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge CLK) begin
        if (mul_start === 1'b1) starts++;
        if (done === 1'b1) dones++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change just after negedge; checks follow #1 later.
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic rd_hi(input string tag, input logic [W-1:0] exp);
        mfhi = 1'b1; mflo = 1'b0; #1;
        chk(tag, 32'(rd_data), 32'(exp));
        mfhi = 1'b0;
    endtask

    task automatic rd_lo(input string tag, input logic [W-1:0] exp);
        mfhi = 1'b0; mflo = 1'b1; #1;
        chk(tag, 32'(rd_data), 32'(exp));
        mflo = 1'b0;
    endtask

    initial begin
        RST = 1'b1; req = 1'b0; op_a = '0; op_b = '0;
        mul_result = '0; mul_valid = 1'b0;
        mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        wr_data = '0;
        tick(); tick();
        RST = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_start", 32'(mul_start), 0);
        chk("rst_err", 32'(err), 0);
        rd_hi("rst_hi", 0);
        rd_lo("rst_lo", 0);

        // 1: 11*14 = 154, valid 6 cycles after start
        s0 = starts;
        req = 1'b1; op_a = 5'd11; op_b = 5'd14;
        tick();
        req = 1'b0; op_a = '0; op_b = '0;
        chk("t1_start", 32'(mul_start), 1);
        chk("t1_op1", 32'(mul_op1), 11);
        chk("t1_op2", 32'(mul_op2), 14);
        chk("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 5; i++) tick();
        chk("t1_op1_hold", 32'(mul_op1), 11);
        chk("t1_nodone", 32'(done), 0);
        mul_valid = 1'b1; mul_result = 10'd154;
        tick();
        mul_valid = 1'b0; mul_result = '0;
        chk("t1_done", 32'(done), 1);
        chk("t1_op2_hold", 32'(mul_op2), 14);
        rd_hi("t1_hi", 5'd4);
        rd_lo("t1_lo", 5'd26);
        tick();
        chk("t1_done_off", 32'(done), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_one_start", 32'(starts - s0), 1);
        rd_hi("t1_mfhi", 5'd4);

        // 2: -3*7 = -21 -> 1003
        req = 1'b1; op_a = 5'b11101; op_b = 5'd7;
        tick();
        req = 1'b0;
        tick();
        mul_valid = 1'b1; mul_result = 10'd1003;
        tick();
        mul_valid = 1'b0;
        chk("t2_done", 32'(done), 1);
        rd_hi("t2_hi", 5'd31);
        rd_lo("t2_lo", 5'd11);
        tick();

        // 3: moves during WAIT are suppressed
        req = 1'b1; op_a = 5'd2; op_b = 5'd3;
        tick();
        req = 1'b0;
        tick();
        mflo = 1'b1; mthi = 1'b1; wr_data = 5'd17; #1;
        chk("t3_stall", 32'(stall), 1);
        tick();
        mflo = 1'b0; mthi = 1'b0;
        rd_hi("t3_hi_kept", 5'd31);
        mul_valid = 1'b1; mul_result = 10'd6;
        tick();
        mul_valid = 1'b0;
        rd_lo("t3_lo_prod", 5'd6);
        tick();
        mthi = 1'b1; wr_data = 5'd9; #1;
        chk("t3_nostall", 32'(stall), 0);
        tick();
        mthi = 1'b0;
        rd_hi("t3_mthi", 5'd9);

        // 4: req while busy ignored; reset mid-WAIT, late valid
        s0 = starts; d0 = dones;
        req = 1'b1; op_a = 5'd1; op_b = 5'd1;
        tick();
        op_a = 5'd20;
        tick();
        tick();
        req = 1'b0;
        chk("t4_op_kept", 32'(mul_op1), 1);
        chk("t4_one_start", 32'(starts - s0), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        mul_valid = 1'b1; mul_result = 10'h3FF;
        tick();
        mul_valid = 1'b0;
        tick();
        chk("t4_idle", 32'(busy), 0);
        chk("t4_no_done", 32'(dones - d0), 0);
        rd_hi("t4_hi_zero", 0);
        rd_lo("t4_lo_zero", 0);

        // 5: req + mtlo together in IDLE
        req = 1'b1; op_a = 5'd3; op_b = 5'd4; mtlo = 1'b1; wr_data = 5'd5;
        tick();
        req = 1'b0; mtlo = 1'b0;
        chk("t5_accepted", 32'(mul_start), 1);
        rd_lo("t5_lo_move", 5'd5);
        tick();
        mul_valid = 1'b1; mul_result = 10'd12;
        tick();
        mul_valid = 1'b0;
        rd_lo("t5_lo_prod", 5'd12);
        rd_hi("t5_hi_prod", 0);
        tick();

`ifdef MUL_TIMEOUT_EN
        // 6: no valid ever -> timeout after 8 WAIT cycles
        req = 1'b1; op_a = 5'd7; op_b = 5'd7;
        tick();
        req = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("t6_still_wait", 32'(busy), 1);
        chk("t6_no_err_yet", 32'(err), 0);
        tick();
        chk("t6_err", 32'(err), 1);
        chk("t6_idle", 32'(busy), 0);
        rd_lo("t6_lo_kept", 5'd12);
        rd_hi("t6_hi_kept", 0);
        tick(); tick();
        chk("t6_sticky", 32'(err), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0; #1;
        chk("t6_err_clr", 32'(err), 0);
`else
        chk("err_tied", 32'(err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
